// File: rtl/arith_divf_share_arb.sv
// Shares one floating-point divider among NUM_REQ requesters: a round-robin arbiter fills a
// one-entry issue slot, and a tag FIFO steers each in-order divider result back to its issuer.
module arith_divf_share_arb #(
    parameter int WIDTH        = 32,
    parameter int NUM_REQ      = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_a_valid,
    output logic [NUM_REQ-1:0]                 req_a_ready,
    input  logic [NUM_REQ*WIDTH-1:0]           req_a_data,
    input  logic [NUM_REQ-1:0]                 req_b_valid,
    output logic [NUM_REQ-1:0]                 req_b_ready,
    input  logic [NUM_REQ*WIDTH-1:0]           req_b_data,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    input  logic [NUM_REQ-1:0]                 rsp_ready,
    output logic [WIDTH-1:0]                   rsp_data,
    output logic                               div_a_valid,
    input  logic                               div_a_ready,
    output logic [WIDTH-1:0]                   div_a_data,
    output logic                               div_b_valid,
    input  logic                               div_b_ready,
    output logic [WIDTH-1:0]                   div_b_data,
    input  logic                               div_r_valid,
    output logic                               div_r_ready,
    input  logic [WIDTH-1:0]                   div_r_data,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
        $fatal(1, "arith_divf_share_arb: WIDTH must be 32 or 64");
    end
    if (NUM_REQ < 2) begin : g_bad_num_req
        $fatal(1, "arith_divf_share_arb: NUM_REQ must be at least 2");
    end
    if (MAX_INFLIGHT < 1) begin : g_bad_inflight
        $fatal(1, "arith_divf_share_arb: MAX_INFLIGHT must be at least 1");
    end

    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;

    logic               slot_v;
    logic [WIDTH-1:0]   slot_a;
    logic [WIDTH-1:0]   slot_b;
    logic [IDX_W-1:0]   slot_tag;

    logic [IDX_W-1:0]   tag_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               fifo_empty;
    logic               load_ok;
    logic               accept;
    logic               slot_fire;
    logic [IDX_W-1:0]   rtag;
    logic               route_ok;
    logic               r_fire;
    logic               bypass;
    logic               push;
    logic               pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign eligible = req_a_valid & req_b_valid;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(rr_ptr) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!grant_any && eligible[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign grant       = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
    assign fifo_empty  = (count == '0);
    assign div_a_valid = slot_v && (count < CNT_W'(MAX_INFLIGHT));
    assign div_b_valid = div_a_valid;
    assign div_a_data  = slot_a;
    assign div_b_data  = slot_b;
    assign slot_fire   = div_a_valid & div_a_ready & div_b_ready;
    assign load_ok     = !slot_v | slot_fire;
    assign accept      = grant_any & load_ok;
    assign req_a_ready = load_ok ? grant : '0;
    assign req_b_ready = req_a_ready;

    // An empty FIFO means the result belongs to the op issuing right now (combinational divider).
    assign rtag     = fifo_empty ? slot_tag : tag_mem[rd_ptr];
    assign route_ok = div_r_valid & (!fifo_empty | slot_v);

    always_comb begin
        rsp_valid = '0;
        if (route_ok) begin
            rsp_valid[rtag] = 1'b1;
        end
    end

    assign div_r_ready = route_ok & rsp_ready[rtag];
    assign rsp_data    = div_r_data;
    assign r_fire      = div_r_valid & div_r_ready;
    assign bypass      = r_fire & fifo_empty;
    assign pop         = r_fire & !fifo_empty;
    assign push        = slot_fire & !bypass;
    assign inflight    = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_v   <= 1'b0;
            slot_a   <= '0;
            slot_b   <= '0;
            slot_tag <= '0;
            rr_ptr   <= IDX_W'(NUM_REQ - 1);
        end else begin
            if (accept) begin
                slot_v   <= 1'b1;
                slot_a   <= req_a_data[int'(grant_idx)*WIDTH +: WIDTH];
                slot_b   <= req_b_data[int'(grant_idx)*WIDTH +: WIDTH];
                slot_tag <= grant_idx;
                rr_ptr   <= grant_idx;
            end else if (slot_fire) begin
                slot_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Tag storage needs no reset; entries are only read while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= slot_tag;
        end
    end

endmodule

// File: tb/tb_arith_divf_share_arb.sv
// Directed bench for arith_divf_share_arb with a switchable combinational / 3-stage pipelined
// divider model; expected quotients are hand-computed IEEE-754 single-precision constants.
module tb_arith_divf_share_arb;

    localparam int WIDTH        = 32;
    localparam int NUM_REQ      = 4;
    localparam int MAX_INFLIGHT = 2;
    localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1);

    // 6/2=3, 8/4=2, 1/2=0.5, 10/4=2.5
    localparam logic [31:0] OP_A [4] = '{32'h40C00000, 32'h41000000, 32'h3F800000, 32'h41200000};
    localparam logic [31:0] OP_B [4] = '{32'h40000000, 32'h40800000, 32'h40000000, 32'h40800000};
    localparam logic [31:0] QUOT [4] = '{32'h40400000, 32'h40000000, 32'h3F000000, 32'h40200000};

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_REQ-1:0]         req_a_valid;
    logic [NUM_REQ-1:0]         req_a_ready;
    logic [NUM_REQ*WIDTH-1:0]   req_a_data;
    logic [NUM_REQ-1:0]         req_b_valid;
    logic [NUM_REQ-1:0]         req_b_ready;
    logic [NUM_REQ*WIDTH-1:0]   req_b_data;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [NUM_REQ-1:0]         rsp_ready;
    logic [WIDTH-1:0]           rsp_data;
    logic                       div_a_valid;
    logic                       div_a_ready;
    logic [WIDTH-1:0]           div_a_data;
    logic                       div_b_valid;
    logic                       div_b_ready;
    logic [WIDTH-1:0]           div_b_data;
    logic                       div_r_valid;
    logic                       div_r_ready;
    logic [WIDTH-1:0]           div_r_data;
    logic [CNT_W-1:0]           inflight;

    logic                       pipe_mode;
    logic [2:0]                 p_v;
    logic [31:0]                p_d [3];
    logic                       stall;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    arith_divf_share_arb #(
        .WIDTH        (WIDTH),
        .NUM_REQ      (NUM_REQ),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_a_valid (req_a_valid),
        .req_a_ready (req_a_ready),
        .req_a_data  (req_a_data),
        .req_b_valid (req_b_valid),
        .req_b_ready (req_b_ready),
        .req_b_data  (req_b_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .div_a_valid (div_a_valid),
        .div_a_ready (div_a_ready),
        .div_a_data  (div_a_data),
        .div_b_valid (div_b_valid),
        .div_b_ready (div_b_ready),
        .div_b_data  (div_b_data),
        .div_r_valid (div_r_valid),
        .div_r_ready (div_r_ready),
        .div_r_data  (div_r_data),
        .inflight    (inflight)
    );

    function automatic logic [63:0] f2d(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return {f[31], 63'd0};
        e = {3'b000, f[30:23]} + 11'd896;
        return {f[31], e, f[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        real         q;
        logic [63:0] d;
        logic [10:0] e;
        q = $bitstoreal(f2d(a)) / $bitstoreal(f2d(b));
        d = $realtobits(q);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [3:0] oh(input int i);
        return 4'(1) << i;
    endfunction

    // Divider model: combinational (ready follows result ready) or a 3-stage stallable pipeline.
    assign stall       = p_v[2] & ~div_r_ready;
    assign div_a_ready = pipe_mode ? ~stall : div_r_ready;
    assign div_b_ready = div_a_ready;
    assign div_r_valid = pipe_mode ? p_v[2] : (div_a_valid & div_b_valid);
    assign div_r_data  = pipe_mode ? p_d[2] : fdiv(div_a_data, div_b_data);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p_v <= '0;
        end else if (!stall) begin
            p_v    <= {p_v[1:0], pipe_mode & div_a_valid & div_b_valid & div_a_ready & div_b_ready};
            p_d[0] <= fdiv(div_a_data, div_b_data);
            p_d[1] <= p_d[0];
            p_d[2] <= p_d[1];
        end
    end

    task automatic do_reset(input logic pipe);
        rst         = 1'b1;
        pipe_mode   = pipe;
        req_a_valid = '0;
        req_b_valid = '0;
        rsp_ready   = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst         = 1'b1;
        pipe_mode   = 1'b0;
        req_a_valid = '0;
        req_b_valid = '0;
        rsp_ready   = '1;
        @(negedge clk);
        #1;
        vectors++;
        if (div_a_valid !== 1'b0 || div_b_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_div_valid: got a=%b b=%b expected 0 0", div_a_valid, div_b_valid);
        end
        vectors++;
        if (rsp_valid !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_rsp_valid: got %b expected 0000", rsp_valid);
        end
        vectors++;
        if (inflight !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_inflight: got %0d expected 0", inflight);
        end
        vectors++;
        if (div_r_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_div_r_ready: got %b expected 0", div_r_ready);
        end
        @(negedge clk);
        rst         = 1'b0;
        req_a_valid = 4'b1111;
        req_b_valid = 4'b1111;
        #1;
        vectors++;
        if (req_a_ready !== 4'b0001 || req_b_ready !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL reset_first_grant: got a=%b b=%b expected 0001", req_a_ready, req_b_ready);
        end
        req_a_valid = '0;
        req_b_valid = '0;
    endtask

    task automatic test_single;
        do_reset(1'b0);
        req_a_valid = 4'b0001;
        req_b_valid = 4'b0001;
        #1;
        vectors++;
        if (req_a_ready !== 4'b0001 || req_b_ready !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL single_accept: got a=%b b=%b expected 0001", req_a_ready, req_b_ready);
        end
        vectors++;
        if (rsp_valid !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL single_early_rsp: got %b expected 0000", rsp_valid);
        end
        @(negedge clk);
        req_a_valid = '0;
        req_b_valid = '0;
        #1;
        vectors++;
        if (rsp_valid !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL single_rsp_valid: got %b expected 0001", rsp_valid);
        end
        vectors++;
        if (rsp_data !== 32'h40400000) begin
            miscompares++;
            $display("[TB] FAIL single_rsp_data: got %h expected 40400000", rsp_data);
        end
        vectors++;
        if (inflight !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL single_inflight: got %0d expected 0", inflight);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 4'b0000 || div_a_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_idle: got rsp=%b div_a_valid=%b expected 0000 0", rsp_valid, div_a_valid);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_rsp;
        do_reset(1'b0);
        req_a_valid = 4'b1111;
        req_b_valid = 4'b1111;
        for (int cyc = 0; cyc < 8; cyc++) begin
            #1;
            vectors++;
            if (req_a_ready !== oh(cyc % 4) || req_b_ready !== oh(cyc % 4)) begin
                miscompares++;
                $display("[TB] FAIL rr_grant cyc %0d: got a=%b b=%b expected %b",
                         cyc, req_a_ready, req_b_ready, oh(cyc % 4));
            end
            exp_rsp = (cyc == 0) ? 4'b0000 : oh((cyc - 1) % 4);
            vectors++;
            if (rsp_valid !== exp_rsp) begin
                miscompares++;
                $display("[TB] FAIL rr_rsp_valid cyc %0d: got %b expected %b", cyc, rsp_valid, exp_rsp);
            end
            if (cyc > 0) begin
                vectors++;
                if (rsp_data !== QUOT[(cyc - 1) % 4]) begin
                    miscompares++;
                    $display("[TB] FAIL rr_rsp_data cyc %0d: got %h expected %h",
                             cyc, rsp_data, QUOT[(cyc - 1) % 4]);
                end
            end
            @(negedge clk);
        end
        req_a_valid = '0;
        req_b_valid = '0;
        #1;
        vectors++;
        if (rsp_valid !== 4'b1000 || rsp_data !== QUOT[3]) begin
            miscompares++;
            $display("[TB] FAIL rr_last_rsp: got %b/%h expected 1000/%h", rsp_valid, rsp_data, QUOT[3]);
        end
    endtask

    task automatic test_one_sided;
        do_reset(1'b0);
        req_a_valid = 4'b1010;
        req_b_valid = 4'b1000;
        for (int cyc = 0; cyc < 4; cyc++) begin
            #1;
            vectors++;
            if (req_a_ready !== 4'b1000 || req_b_ready !== 4'b1000) begin
                miscompares++;
                $display("[TB] FAIL one_sided_grant cyc %0d: got a=%b b=%b expected 1000",
                         cyc, req_a_ready, req_b_ready);
            end
            if (cyc > 0) begin
                vectors++;
                if (rsp_valid !== 4'b1000 || rsp_data !== QUOT[3]) begin
                    miscompares++;
                    $display("[TB] FAIL one_sided_rsp cyc %0d: got %b/%h expected 1000/%h",
                             cyc, rsp_valid, rsp_data, QUOT[3]);
                end
            end
            @(negedge clk);
        end
        req_a_valid = '0;
        req_b_valid = '0;
    endtask

    task automatic test_pipeline;
        int exp_idx    = 0;
        int resp_count = 0;
        do_reset(1'b1);
        req_a_valid = 4'b1111;
        req_b_valid = 4'b1111;
        for (int cyc = 0; cyc < 24; cyc++) begin
            #1;
            vectors++;
            if (inflight > 2'd2) begin
                miscompares++;
                $display("[TB] FAIL pipe_inflight_max cyc %0d: got %0d expected <= 2", cyc, inflight);
            end
            if (inflight == 2'd2) begin
                vectors++;
                if (div_a_valid !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL pipe_full_block cyc %0d: got div_a_valid=%b expected 0", cyc, div_a_valid);
                end
            end
            if (cyc == 3) begin
                vectors++;
                if (inflight !== 2'd2) begin
                    miscompares++;
                    $display("[TB] FAIL pipe_fill cyc 3: got inflight=%0d expected 2", inflight);
                end
            end
            if ((rsp_valid & rsp_ready) != 4'b0000) begin
                vectors++;
                if (rsp_valid !== oh(exp_idx) || rsp_data !== QUOT[exp_idx]) begin
                    miscompares++;
                    $display("[TB] FAIL pipe_order cyc %0d: got %b/%h expected %b/%h",
                             cyc, rsp_valid, rsp_data, oh(exp_idx), QUOT[exp_idx]);
                end
                exp_idx = (exp_idx + 1) % 4;
                resp_count++;
            end
            @(negedge clk);
        end
        vectors++;
        if (resp_count != 10) begin
            miscompares++;
            $display("[TB] FAIL pipe_resp_count: got %0d expected 10", resp_count);
        end
        req_a_valid = '0;
        req_b_valid = '0;
    endtask

    task automatic test_back_to_back_stall;
        int exp_idx      = 0;
        int resp_count   = 0;
        int stall_cycles = 0;
        do_reset(1'b1);
        req_a_valid = 4'b1111;
        req_b_valid = 4'b1111;
        for (int cyc = 0; cyc < 28; cyc++) begin
            rsp_ready = (stall_cycles >= 5) ? 4'b1111 : 4'b1011;
            #1;
            if (rsp_valid[2] && stall_cycles < 5) begin
                vectors++;
                if (rsp_valid !== 4'b0100 || div_r_ready !== 1'b0 || rsp_data !== QUOT[2]) begin
                    miscompares++;
                    $display("[TB] FAIL stall_hold cyc %0d: got rsp=%b r_ready=%b data=%h expected 0100 0 %h",
                             cyc, rsp_valid, div_r_ready, rsp_data, QUOT[2]);
                end
                vectors++;
                if (inflight !== 2'd2) begin
                    miscompares++;
                    $display("[TB] FAIL stall_inflight cyc %0d: got %0d expected 2", cyc, inflight);
                end
                stall_cycles++;
            end
            if ((rsp_valid & rsp_ready) != 4'b0000) begin
                vectors++;
                if (rsp_valid !== oh(exp_idx) || rsp_data !== QUOT[exp_idx]) begin
                    miscompares++;
                    $display("[TB] FAIL stall_order cyc %0d: got %b/%h expected %b/%h",
                             cyc, rsp_valid, rsp_data, oh(exp_idx), QUOT[exp_idx]);
                end
                exp_idx = (exp_idx + 1) % 4;
                resp_count++;
            end
            @(negedge clk);
        end
        vectors++;
        if (stall_cycles != 5) begin
            miscompares++;
            $display("[TB] FAIL stall_seen: got %0d stalled cycles expected 5", stall_cycles);
        end
        vectors++;
        if (resp_count != 10) begin
            miscompares++;
            $display("[TB] FAIL stall_resp_count: got %0d expected 10", resp_count);
        end
        req_a_valid = '0;
        req_b_valid = '0;
        rsp_ready   = '1;
    endtask

    task automatic test_reset_midop;
        do_reset(1'b1);
        req_a_valid = 4'b1111;
        req_b_valid = 4'b1111;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (inflight !== 2'd2 || div_a_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midop_pre: got inflight=%0d div_a_valid=%b expected 2 0", inflight, div_a_valid);
        end
        req_a_valid = '0;
        req_b_valid = '0;
        rst = 1'b1;
        #1;
        vectors++;
        if (div_a_valid !== 1'b0 || rsp_valid !== 4'b0000 || inflight !== 2'd0 || div_r_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midop_in_reset: got a_valid=%b rsp=%b inflight=%0d r_ready=%b expected 0 0000 0 0",
                     div_a_valid, rsp_valid, inflight, div_r_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (div_a_valid !== 1'b0 || div_b_valid !== 1'b0 || inflight !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL midop_slot_dropped: got a_valid=%b b_valid=%b inflight=%0d expected 0 0 0",
                     div_a_valid, div_b_valid, inflight);
        end
        req_a_valid = 4'b1111;
        req_b_valid = 4'b1111;
        #1;
        vectors++;
        if (req_a_ready !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL midop_next_grant: got %b expected 0001", req_a_ready);
        end
        req_a_valid = '0;
        req_b_valid = '0;
    endtask

    initial begin
        rst         = 1'b1;
        pipe_mode   = 1'b0;
        req_a_valid = '0;
        req_b_valid = '0;
        rsp_ready   = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a_data[i*WIDTH +: WIDTH] = OP_A[i];
            req_b_data[i*WIDTH +: WIDTH] = OP_B[i];
        end
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_one_sided();
        test_pipeline();
        test_back_to_back_stall();
        test_reset_midop();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
